// File: rtl/rggen_adapter_core.sv
// ============================================================================
// Module   : rggen_adapter_core
// Brief    : Bus-to-register adapter core with optional request slicer and
//            access watchdog. Watchdog built only with RGGEN_ADAPTER_TIMEOUT_EN;
//            properties built only with RGGEN_ENABLE_SVA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rggen_adapter_core #(
    parameter int                    BUS_WIDTH         = 32,
    parameter int                    ADDRESS_WIDTH     = 16,
    parameter int                    REGISTERS         = 1,
    parameter bit                    ERROR_STATUS      = 1'b0,
    parameter logic [BUS_WIDTH-1:0]  DEFAULT_READ_DATA = '0,
    parameter bit                    INSERT_SLICER     = 1'b0,
    parameter int                    TIMEOUT_CYCLES    = 0
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    // bus side
    input  logic                            i_bus_valid,
    input  logic [1:0]                      i_bus_access,
    input  logic [ADDRESS_WIDTH-1:0]        i_bus_address,
    input  logic [BUS_WIDTH-1:0]            i_bus_write_data,
    input  logic [BUS_WIDTH/8-1:0]          i_bus_strobe,
    output logic                            o_bus_ready,
    output logic [1:0]                      o_bus_status,
    output logic [BUS_WIDTH-1:0]            o_bus_read_data,
    // register side (request fields broadcast, valid per channel)
    output logic [REGISTERS-1:0]            o_reg_valid,
    output logic [1:0]                      o_reg_access,
    output logic [ADDRESS_WIDTH-1:0]        o_reg_address,
    output logic [BUS_WIDTH-1:0]            o_reg_write_data,
    output logic [BUS_WIDTH/8-1:0]          o_reg_strobe,
    input  logic [REGISTERS-1:0]            i_reg_active,
    input  logic [REGISTERS-1:0]            i_reg_ready,
    input  logic [2*REGISTERS-1:0]          i_reg_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0]  i_reg_read_data,
    output logic                            o_timeout
);

    localparam logic [1:0] c_OKAY        = 2'b00;
    localparam logic [1:0] c_SLAVE_ERROR = 2'b10;
    localparam logic [1:0] c_UNMAPPED_STATUS = ERROR_STATUS ? c_SLAVE_ERROR : c_OKAY;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic                   r_bus_ready_q;
    logic                   w_start;
    logic                   w_hit;
    logic                   w_unmapped;
    logic                   w_finish;
    logic                   w_expire;
    logic [1:0]             w_rsp_status;
    logic [BUS_WIDTH-1:0]   w_rsp_data;

    // A new access may not start in the cycle right after a completion, and
    // nothing may be issued while reset is applied.
    assign w_start    = i_bus_valid && !r_bus_ready_q && i_rst_n;
    assign w_unmapped = ~|i_reg_active;
    assign w_finish   = w_hit || w_unmapped;

    generate
        if (INSERT_SLICER) begin : g_slicer
            logic [1:0]               r_slice_access;
            logic [ADDRESS_WIDTH-1:0] r_slice_address;
            logic [BUS_WIDTH-1:0]     r_slice_write_data;
            logic [BUS_WIDTH/8-1:0]   r_slice_strobe;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_slice_access     <= '0;
                    r_slice_address    <= '0;
                    r_slice_write_data <= '0;
                    r_slice_strobe     <= '0;
                end else if (r_state == ST_IDLE && w_start) begin
                    r_slice_access     <= i_bus_access;
                    r_slice_address    <= i_bus_address;
                    r_slice_write_data <= i_bus_write_data;
                    r_slice_strobe     <= i_bus_strobe;
                end
            end

            assign o_reg_access     = r_slice_access;
            assign o_reg_address    = r_slice_address;
            assign o_reg_write_data = r_slice_write_data;
            assign o_reg_strobe     = r_slice_strobe;
        end else begin : g_no_slicer
            assign o_reg_access     = i_bus_access;
            assign o_reg_address    = i_bus_address;
            assign o_reg_write_data = i_bus_write_data;
            assign o_reg_strobe     = i_bus_strobe;
        end
    endgenerate

`ifdef RGGEN_ADAPTER_TIMEOUT_EN
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_watchdog
            localparam int             c_CW      = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(TIMEOUT_CYCLES);
            localparam logic [c_CW-1:0] c_CNT_EXP = c_CW'(TIMEOUT_CYCLES - 1);
            logic [c_CW-1:0] r_count;

            // Held at zero outside WAIT, so every entry into WAIT starts from 0.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_count <= '0;
                end else if (r_state != ST_WAIT) begin
                    r_count <= '0;
                end else if (r_count != c_CNT_MAX) begin
                    r_count <= r_count + c_CW'(1);
                end
            end

            assign w_expire = (r_state == ST_WAIT) && (r_count == c_CNT_EXP);
        end else begin : g_no_watchdog
            assign w_expire = 1'b0;
        end
    endgenerate
`else
    assign w_expire = 1'b0;
`endif

    // Lowest-indexed ready channel wins.
    always_comb begin
        w_hit        = 1'b0;
        w_rsp_status = c_UNMAPPED_STATUS;
        w_rsp_data   = DEFAULT_READ_DATA;
        for (int i = REGISTERS - 1; i >= 0; i--) begin
            if (i_reg_ready[i]) begin
                w_hit        = 1'b1;
                w_rsp_status = i_reg_status[2*i +: 2];
                w_rsp_data   = i_reg_read_data[BUS_WIDTH*i +: BUS_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_bus_ready_q <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_bus_ready_q <= o_bus_ready;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        o_reg_valid     = '0;
        o_bus_ready     = 1'b0;
        o_bus_status    = w_rsp_status;
        o_bus_read_data = w_rsp_data;
        o_timeout       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (INSERT_SLICER) begin
                        w_state_next = ST_ISSUE;
                    end else begin
                        o_reg_valid = '1;
                        if (w_finish) begin
                            o_bus_ready = 1'b1;
                        end else begin
                            w_state_next = ST_WAIT;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                o_reg_valid = '1;
                if (w_finish) begin
                    o_bus_ready  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_finish) begin
                    o_bus_ready  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_expire) begin
                    o_bus_ready     = 1'b1;
                    o_bus_status    = c_SLAVE_ERROR;
                    o_bus_read_data = DEFAULT_READ_DATA;
                    o_timeout       = 1'b1;
                    w_state_next    = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

`ifdef RGGEN_ENABLE_SVA
    a_req_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_bus_valid && !o_bus_ready && !r_bus_ready_q) |=>
        (i_bus_valid && $stable({i_bus_access, i_bus_address, i_bus_write_data, i_bus_strobe})));
    a_active_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(i_reg_active));
    a_ready_no_b2b: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_bus_ready |=> !o_bus_ready);
`endif

endmodule

`default_nettype wire

// File: tb/tb_rggen_adapter_core.sv
// Testbench for rggen_adapter_core: slicer-off (k=0) and slicer-on (k=1)
// instances, checked against a cycle-count reference model.
`default_nettype none

module tb_rggen_adapter_core;

    localparam int                TMO   = 8;
    localparam logic [31:0]       DEF   = 32'h0BAD0BAD;
    localparam logic [1:0]        OKAY  = 2'b00;
    localparam logic [1:0]        SLERR = 2'b10;
`ifdef RGGEN_ADAPTER_TIMEOUT_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]             bus_valid;
    logic [1:0][1:0]        bus_access;
    logic [1:0][15:0]       bus_addr;
    logic [1:0][31:0]       bus_wdata;
    logic [1:0][3:0]        bus_strobe;
    logic [1:0]             bus_ready;
    logic [1:0][1:0]        bus_status;
    logic [1:0][31:0]       bus_rdata;
    logic [1:0][3:0]        reg_valid;
    logic [1:0][1:0]        reg_access;
    logic [1:0][15:0]       reg_addr;
    logic [1:0][31:0]       reg_wdata;
    logic [1:0][3:0]        reg_strobe;
    logic [1:0][3:0]        reg_active;
    logic [1:0][3:0]        reg_ready;
    logic [1:0][7:0]        reg_status;
    logic [1:0][127:0]      reg_rdata;
    logic [1:0]             timeout;

    int total = 0;
    int bad   = 0;

    rggen_adapter_core #(
        .BUS_WIDTH(32), .ADDRESS_WIDTH(16), .REGISTERS(4), .ERROR_STATUS(1'b1),
        .DEFAULT_READ_DATA(DEF), .INSERT_SLICER(1'b0), .TIMEOUT_CYCLES(TMO)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_bus_valid(bus_valid[0]), .i_bus_access(bus_access[0]), .i_bus_address(bus_addr[0]),
        .i_bus_write_data(bus_wdata[0]), .i_bus_strobe(bus_strobe[0]),
        .o_bus_ready(bus_ready[0]), .o_bus_status(bus_status[0]), .o_bus_read_data(bus_rdata[0]),
        .o_reg_valid(reg_valid[0]), .o_reg_access(reg_access[0]), .o_reg_address(reg_addr[0]),
        .o_reg_write_data(reg_wdata[0]), .o_reg_strobe(reg_strobe[0]),
        .i_reg_active(reg_active[0]), .i_reg_ready(reg_ready[0]), .i_reg_status(reg_status[0]),
        .i_reg_read_data(reg_rdata[0]), .o_timeout(timeout[0])
    );

    rggen_adapter_core #(
        .BUS_WIDTH(32), .ADDRESS_WIDTH(16), .REGISTERS(4), .ERROR_STATUS(1'b1),
        .DEFAULT_READ_DATA(DEF), .INSERT_SLICER(1'b1), .TIMEOUT_CYCLES(TMO)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_bus_valid(bus_valid[1]), .i_bus_access(bus_access[1]), .i_bus_address(bus_addr[1]),
        .i_bus_write_data(bus_wdata[1]), .i_bus_strobe(bus_strobe[1]),
        .o_bus_ready(bus_ready[1]), .o_bus_status(bus_status[1]), .o_bus_read_data(bus_rdata[1]),
        .o_reg_valid(reg_valid[1]), .o_reg_access(reg_access[1]), .o_reg_address(reg_addr[1]),
        .o_reg_write_data(reg_wdata[1]), .o_reg_strobe(reg_strobe[1]),
        .i_reg_active(reg_active[1]), .i_reg_ready(reg_ready[1]), .i_reg_status(reg_status[1]),
        .i_reg_read_data(reg_rdata[1]), .o_timeout(timeout[1])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus_valid  = '0;
        bus_access = '0;
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_strobe = '0;
        reg_active = '0;
        reg_ready  = '0;
        reg_status = '0;
        reg_rdata  = '0;
    endtask

    // One access on DUT k. sel<0: unmapped. Channel sel answers d cycles after
    // the register-side issue cycle (extra channels answer alongside it).
    task automatic do_access(input int k, input logic [1:0] acc, input logic [15:0] addr,
                             input logic [31:0] wd, input logic [3:0] st, input int sel,
                             input int d, input logic [3:0] extra,
                             input logic [127:0] rd, input logic [7:0] sts);
        int          slc;
        int          ready_at;
        int          lat;
        int          last;
        int          ch;
        bit          timed;
        logic [3:0]  onehot;
        logic [3:0]  mask;
        logic [1:0]  exp_st;
        logic [31:0] exp_rd;
        string       tag;

        slc      = k;
        timed    = 1'b0;
        onehot   = (sel >= 0) ? (4'b0001 << sel) : 4'b0000;
        ready_at = (sel >= 0) ? slc + d : -1;
        if (sel < 0) begin
            lat    = slc;
            exp_st = SLERR;
            exp_rd = DEF;
        end else if (WDT && d > TMO) begin
            lat    = slc + TMO;
            timed  = 1'b1;
            exp_st = SLERR;
            exp_rd = DEF;
        end else begin
            lat  = ready_at;
            mask = onehot | extra;
            ch   = 0;
            for (int i = 3; i >= 0; i--) if (mask[i]) ch = i;
            exp_st = sts[2*ch +: 2];
            exp_rd = rd[32*ch +: 32];
        end
        last = ((ready_at > lat) ? ready_at : lat) + 2;

        for (int n = 0; n <= last; n++) begin
            @(negedge clk);
            bus_valid[k]  = (n <= lat + 1);
            bus_access[k] = acc;
            bus_addr[k]   = addr;
            bus_wdata[k]  = wd;
            bus_strobe[k] = st;
            reg_active[k] = onehot;
            reg_ready[k]  = (n == ready_at) ? (onehot | extra) : 4'b0000;
            reg_status[k] = sts;
            reg_rdata[k]  = rd;
            #1;
            tag = $sformatf("k%0d_n%0d", k, n);
            chk({tag, "_ready"},   bus_ready[k], (n == lat));
            chk({tag, "_timeout"}, timeout[k],   (n == lat) && timed);
            chk({tag, "_regvalid"}, reg_valid[k], (n == slc) ? 4'hF : 4'h0);
            if (n == lat) begin
                chk({tag, "_status"}, bus_status[k], exp_st);
                chk({tag, "_rdata"},  bus_rdata[k],  exp_rd);
            end
            if (n == slc) begin
                chk({tag, "_access"}, reg_access[k], acc);
                chk({tag, "_addr"},   reg_addr[k],   addr);
                chk({tag, "_wdata"},  reg_wdata[k],  wd);
                chk({tag, "_strobe"}, reg_strobe[k], st);
            end
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [127:0] rd;
        logic [7:0]   sts;
        int           sel;

        // reset state, with inputs trying to provoke a response
        rst_n = 1'b0;
        clear_inputs();
        bus_valid  = 2'b11;
        reg_active = {4'b0001, 4'b0001};
        reg_ready  = {4'b0001, 4'b0001};
        #3;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_k%0d_ready", k),    bus_ready[k], 1'b0);
            chk($sformatf("rst_k%0d_regvalid", k), reg_valid[k], 4'h0);
            chk($sformatf("rst_k%0d_timeout", k),  timeout[k],   1'b0);
        end
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // zero-latency read from channel 2
        rd = {32'h11111111, 32'hDEADBEEF, 32'h22222222, 32'h33333333};
        do_access(0, 2'b00, 16'h0010, 32'h0, 4'h0, 2, 0, 4'h0, rd, 8'b10_00_10_10);
        // sliced write to 0x8, channel 1 ready in ISSUE
        rd = {$urandom, $urandom, $urandom, $urandom};
        do_access(1, 2'b01, 16'h0008, 32'hA5A5_1234, 4'b1010, 1, 0, 4'h0, rd, 8'h00);
        // unmapped on both
        do_access(0, 2'b00, 16'h0FF0, 32'h0, 4'h0, -1, 0, 4'h0, rd, 8'h00);
        do_access(1, 2'b00, 16'h0FF4, 32'h0, 4'h0, -1, 0, 4'h0, rd, 8'h00);
        // never-ready within the limit, late ready two cycles after expiry
        do_access(0, 2'b00, 16'h0020, 32'h0, 4'h0, 0, TMO + 2, 4'h0, rd, 8'h00);
        do_access(1, 2'b01, 16'h0024, 32'h77, 4'hF, 3, TMO + 2, 4'h0, rd, 8'h00);
        // ready on the last WAIT cycle
        do_access(0, 2'b00, 16'h0030, 32'h0, 4'h0, 3, TMO, 4'h0, rd, 8'b01_00_00_00);
        do_access(1, 2'b00, 16'h0034, 32'h0, 4'h0, 2, TMO, 4'h0, rd, 8'b00_01_00_00);
        // several readies: lowest index wins
        do_access(0, 2'b00, 16'h0040, 32'h0, 4'h0, 1, 2, 4'b1000, rd, 8'b00_00_01_00);
        do_access(1, 2'b00, 16'h0044, 32'h0, 4'h0, 3, 1, 4'b0101, rd, 8'b00_00_00_01);

        // reset while the sliced access sits in WAIT
        @(negedge clk);
        bus_valid[1] = 1'b1; bus_addr[1] = 16'h0050; reg_active[1] = 4'b0010;
        @(negedge clk);
        #1 chk("rstmid_issue_regvalid", reg_valid[1], 4'hF);
        @(negedge clk);
        #1 chk("rstmid_wait_regvalid", reg_valid[1], 4'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        reg_ready[1] = 4'b0010;
        #1;
        chk("rstmid_ready",    bus_ready[1], 1'b0);
        chk("rstmid_regvalid", reg_valid[1], 4'h0);
        chk("rstmid_timeout",  timeout[1],   1'b0);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        rd = {$urandom, $urandom, $urandom, $urandom};
        do_access(1, 2'b00, 16'h0054, 32'h0, 4'h0, 1, 1, 4'h0, rd, 8'h00);

        // randomized accesses on both instances
        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 4));
            if (sel == 4) sel = -1;
            rd  = {$urandom, $urandom, $urandom, $urandom};
            sts = 8'($urandom);
            do_access(i % 2, 2'($urandom), 16'($urandom), $urandom, 4'($urandom), sel,
                      int'($urandom_range(0, TMO + 3)),
                      ($urandom_range(0, 3) == 0 && sel >= 0) ? 4'($urandom) : 4'h0,
                      rd, sts);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
